exe_mem_pipe_reg: RTL and testbench
===================================

Name: exe_mem_pipe_reg

Overview:
Parametrised EXE→MEM pipeline stage register that replaces the fixed 16-bit, free-running stage.
- Adds a valid/ready handshake on both sides so EXE can be stalled by a multi-cycle MEM stage.
- Adds a 1-entry skid buffer so in_ready is a registered signal, with full throughput.
- Adds a synchronous flush for branch or exception squash.
- Control fields of bubbles are forced inactive, so no spurious register write reaches writeback.

Parameters:
DATA_W, 16, width of alu_result and rdata2 paths
WADDR_W, 4, width of the register-file write address

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held and incoming entries
in_valid  in  1  EXE presents a valid instruction
in_ready  out  1  stage can accept; registered
alu_result  in  DATA_W  ALU result
rdata2  in  DATA_W  store data (register read port 2)
mem_to_reg  in  1  writeback selects memory data
reg_wen  in  1  register-file write enable
reg_waddr  in  WADDR_W  register-file write address
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM consumes the entry this cycle
alu_result_out  out  DATA_W  held ALU result
rdata2_out  out  DATA_W  held store data
mem_to_reg_out  out  1  held mem_to_reg, gated by out_valid
reg_wen_out  out  1  held reg_wen, gated by out_valid
reg_waddr_out  out  WADDR_W  held write address
stall_cnt  out  32  MEM back-pressure cycle count (only with optional feature)

Behaviour:
- State: main slot (payload + out_valid) and skid slot (payload + skid_valid).
- Reset (rst_n=0, asynchronous):
  - out_valid=0, skid_valid=0, in_ready=1.
  - All payload outputs 0: alu_result_out, rdata2_out, reg_waddr_out, mem_to_reg_out, reg_wen_out.
  - stall_cnt=0.
  - Reset released mid-transfer: nothing held survives.
- Accept: acc = in_valid & in_ready. Drain: drn = out_valid & out_ready.
- Next-state rules, per posedge, with flush=0:
  - skid_valid=0, acc, and (out_valid=0 or drn): input goes to main slot; out_valid=1.
  - skid_valid=0, acc, out_valid=1, no drn: input goes to skid slot; skid_valid=1.
  - skid_valid=0, no acc, drn: out_valid=0.
  - skid_valid=1, drn: skid moves to main slot; skid_valid=0; out_valid stays 1. No acc is possible because in_ready=0.
  - skid_valid=1, no drn: hold everything.
- in_ready is registered: in_ready = !skid_valid_next.
- Latency: input to output is 1 cycle.
- Throughput: 1 entry per cycle while out_ready=1. Ordering is strictly FIFO.
- flush=1 (synchronous, highest priority):
  - Next cycle: out_valid=0, skid_valid=0, in_ready=1.
  - Same-cycle input is discarded.
  - Any drain in the flush cycle still counts as a completed transfer.
- Bubble gating:
  - reg_wen_out = out_valid & stored reg_wen; mem_to_reg_out likewise.
  - Data outputs keep their last value when out_valid=0.
- out_valid never deasserts without drn or flush.
- Payload outputs are stable while out_valid=1 and out_ready=0.
- Widths are passed through unchanged; no arithmetic on payload.

Optional Feature:
- Macro: EXE_MEM_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 every cycle with out_valid=1 and out_ready=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset only; unaffected by flush.
- Undefined: stall_cnt port and counter are absent.

Decomposition:
- Shared package exe_mem_pkg holds:
  - Default width localparams.
  - Payload field offsets and total payload width: PAYLOAD_W = 2*DATA_W + WADDR_W + 2.
- Sub-module pipe_skid_buf(PAYLOAD_W):
  - Generic valid/ready skid buffer with flush.
  - Wrapper packs and unpacks fields and applies bubble gating.

Test Plan:
1. Reset mid-stream: out_valid=1 with reg_wen_out=1, then assert rst_n=0 → all outputs 0 immediately; in_ready=1 after release.
2. Streaming: out_ready=1, entries alu_result=0x0001..0x0010 each cycle → same sequence on alu_result_out, 1-cycle latency, in_ready never drops.
3. Back-pressure: out_ready=0 for 3 cycles while sending A=0x1234 then B=0x5678 → A held; B in skid; in_ready=0 on the cycle after B. Then out_ready=1 → A, then B, with no loss or duplication.
4. Flush with skid full: flush=1 while in_valid=1 (C=0xBEEF) → next cycle out_valid=0, reg_wen_out=0, in_ready=1; C never appears.
5. Bubble gating: in_valid=0 with reg_wen=1 on input → reg_wen_out and mem_to_reg_out stay 0.
6. With EXE_MEM_STALL_CNT_EN: out_valid=1, out_ready=0 for 5 cycles → stall_cnt=5; a flush afterwards leaves it at 5.

Source files
------------

// File: rtl/exe_mem_pkg.sv
// rtl/exe_mem_pkg.sv - shared widths and payload layout for the EXE->MEM stage register
// Payload packing, LSB first: reg_wen, mem_to_reg, reg_waddr, rdata2, alu_result.
package exe_mem_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int WADDR_W_DEF    = 4;

    localparam int REG_WEN_OFS    = 0;
    localparam int MEM_TO_REG_OFS = 1;
    localparam int WADDR_OFS      = 2;

    function automatic int rdata2_ofs(input int waddr_w);
        return WADDR_OFS + waddr_w;
    endfunction

    function automatic int alu_ofs(input int data_w, input int waddr_w);
        return WADDR_OFS + waddr_w + data_w;
    endfunction

    function automatic int payload_w(input int data_w, input int waddr_w);
        return 2 * data_w + waddr_w + 2;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic valid/ready skid buffer with synchronous flush
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  drop held entries and same-cycle input
//   in_valid/in_ready/in_payload     upstream handshake; in_ready is a flop
//   out_valid/out_ready/out_payload  downstream handshake; out_payload is the main slot
module pipe_skid_buf #(
    parameter int PAYLOAD_W = 38
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic [PAYLOAD_W-1:0] skid_payload;
    logic                 skid_valid;
    logic                 acc;
    logic                 drn;

    assign acc = in_valid & in_ready;
    assign drn = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            skid_valid   <= 1'b0;
            in_ready     <= 1'b1;
            out_payload  <= '0;
            skid_payload <= '0;
        end else if (flush) begin
            // Payload registers keep their contents so data outputs hold
            // their last value across the bubble.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (skid_valid) begin
            // in_ready is low here, so no accept can coincide.
            if (drn) begin
                out_payload <= skid_payload;
                skid_valid  <= 1'b0;
                in_ready    <= 1'b1;
            end
        end else if (acc) begin
            if (!out_valid || drn) begin
                out_payload <= in_payload;
                out_valid   <= 1'b1;
            end else begin
                // Main slot is stuck: park the entry and stop upstream.
                skid_payload <= in_payload;
                skid_valid   <= 1'b1;
                in_ready     <= 1'b0;
            end
        end else if (drn) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// rtl/exe_mem_pipe_reg.sv - EXE->MEM pipeline register with handshake, skid buffer and flush
// Optional macro EXE_MEM_STALL_CNT_EN adds the stall_cnt back-pressure counter port.
// Ports:
//   clk, rst_n, flush                       clock, async active-low reset, squash
//   in_valid/in_ready + EXE fields          upstream side
//   out_valid/out_ready + *_out fields      MEM side; control outputs gated by out_valid
//   stall_cnt                               cycles with out_valid=1 and out_ready=0 (optional)
module exe_mem_pipe_reg
    import exe_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int WADDR_W = WADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  rdata2,
    input  logic               mem_to_reg,
    input  logic               reg_wen,
    input  logic [WADDR_W-1:0] reg_waddr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  alu_result_out,
    output logic [DATA_W-1:0]  rdata2_out,
    output logic               mem_to_reg_out,
    output logic               reg_wen_out,
    output logic [WADDR_W-1:0] reg_waddr_out
`ifdef EXE_MEM_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int PW      = payload_w(DATA_W, WADDR_W);
    localparam int RD2_LSB = rdata2_ofs(WADDR_W);
    localparam int ALU_LSB = alu_ofs(DATA_W, WADDR_W);

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;

    assign in_payload = {alu_result, rdata2, reg_waddr, mem_to_reg, reg_wen};

    pipe_skid_buf #(
        .PAYLOAD_W (PW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload)
    );

    assign alu_result_out = out_payload[ALU_LSB +: DATA_W];
    assign rdata2_out     = out_payload[RD2_LSB +: DATA_W];
    assign reg_waddr_out  = out_payload[WADDR_OFS +: WADDR_W];
    // Bubbles must never write the register file.
    assign mem_to_reg_out = out_valid & out_payload[MEM_TO_REG_OFS];
    assign reg_wen_out    = out_valid & out_payload[REG_WEN_OFS];

`ifdef EXE_MEM_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// tb/tb_exe_mem_pipe_reg.sv - self-checking bench for exe_mem_pipe_reg
module tb_exe_mem_pipe_reg;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] rd2;
        logic [3:0]  wa;
        logic        m2r;
        logic        wen;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] alu_result = '0;
    logic [15:0] rdata2 = '0;
    logic        mem_to_reg = 1'b0;
    logic        reg_wen = 1'b0;
    logic [3:0]  reg_waddr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] alu_result_out;
    logic [15:0] rdata2_out;
    logic        mem_to_reg_out;
    logic        reg_wen_out;
    logic [3:0]  reg_waddr_out;
`ifdef EXE_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;

    exe_mem_pipe_reg #(.DATA_W(16), .WADDR_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .rdata2         (rdata2),
        .mem_to_reg     (mem_to_reg),
        .reg_wen        (reg_wen),
        .reg_waddr      (reg_waddr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_result_out (alu_result_out),
        .rdata2_out     (rdata2_out),
        .mem_to_reg_out (mem_to_reg_out),
        .reg_wen_out    (reg_wen_out),
        .reg_waddr_out  (reg_waddr_out)
`ifdef EXE_MEM_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a FIFO of at most two entries; the head is what MEM sees.
    ent_t        q[$];
    ent_t        last_main = '0;
    logic [31:0] stall_exp = '0;
    int          m_n;
    bit          m_acc;
    bit          m_drn;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            last_main = '0;
            stall_exp = '0;
        end else begin
            m_n   = q.size();
            m_acc = in_valid && (m_n < 2);
            m_drn = (m_n > 0) && out_ready;
            if (m_n > 0 && !out_ready && stall_exp != 32'hFFFF_FFFF)
                stall_exp = stall_exp + 1;
            if (flush) begin
                q.delete();
            end else begin
                if (m_drn) void'(q.pop_front());
                if (m_acc) q.push_back('{alu_result, rdata2, reg_waddr, mem_to_reg, reg_wen});
            end
            if (q.size() > 0) last_main = q[0];
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("alu_result_out", {16'd0, alu_result_out}, {16'd0, last_main.alu});
        chk("rdata2_out", {16'd0, rdata2_out}, {16'd0, last_main.rd2});
        chk("reg_waddr_out", {28'd0, reg_waddr_out}, {28'd0, last_main.wa});
        chk("reg_wen_out", {31'd0, reg_wen_out}, {31'd0, (q.size() > 0) && last_main.wen});
        chk("mem_to_reg_out", {31'd0, mem_to_reg_out}, {31'd0, (q.size() > 0) && last_main.m2r});
`ifdef EXE_MEM_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_exp);
`endif
    end

    task automatic drive(input logic v, input logic [15:0] a, input logic w, input logic rdy);
        in_valid   = v;
        alu_result = a;
        rdata2     = ~a;
        reg_waddr  = a[3:0];
        reg_wen    = w;
        mem_to_reg = w;
        out_ready  = rdy;
    endtask

    initial begin
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Reset mid-stream
        drive(1'b1, 16'h00A5, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_pre_wen", {31'd0, reg_wen_out}, 32'd1);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_wen", {31'd0, reg_wen_out}, 32'd0);
        chk("t1_alu", {16'd0, alu_result_out}, 32'd0);
        chk("t1_waddr", {28'd0, reg_waddr_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef EXE_MEM_STALL_CNT_EN
        // Stall counter: 5 back-pressure cycles, then a flush while draining
        drive(1'b1, 16'h0077, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("t6_cnt", stall_cnt, 32'd5);
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("t6_cnt_after_flush", stall_cnt, 32'd5);
`endif

        // Streaming
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, i[15:0], 1'b0, 1'b1);
            @(negedge clk);
            chk("t2_alu", {16'd0, alu_result_out}, i);
            chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_drained", {31'd0, out_valid}, 32'd0);

        // Back-pressure
        drive(1'b1, 16'h1234, 1'b1, 1'b0);
        @(negedge clk);
        chk("t3_a_held", {16'd0, alu_result_out}, 32'h1234);
        chk("t3_ready_a", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 16'h5678, 1'b1, 1'b0);
        @(negedge clk);
        chk("t3_a_held2", {16'd0, alu_result_out}, 32'h1234);
        chk("t3_ready_b", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_a_held3", {16'd0, alu_result_out}, 32'h1234);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t3_b_out", {16'd0, alu_result_out}, 32'h5678);
        chk("t3_b_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("t3_empty", {31'd0, out_valid}, 32'd0);
        chk("t3_data_hold", {16'd0, alu_result_out}, 32'h5678);

        // Flush with skid full
        drive(1'b1, 16'h1111, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 16'h2222, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_full", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_wen", {31'd0, reg_wen_out}, 32'd0);
        chk("t4_ready", {31'd0, in_ready}, 32'd1);
        chk("t4_no_c", {31'd0, alu_result_out == 16'hBEEF}, 32'd0);

        // Bubble gating
        drive(1'b0, 16'h00FF, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("t5_wen", {31'd0, reg_wen_out}, 32'd0);
            chk("t5_m2r", {31'd0, mem_to_reg_out}, 32'd0);
        end

        // Randomised traffic against the reference FIFO
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            alu_result = $urandom();
            rdata2     = $urandom();
            reg_waddr  = $urandom();
            reg_wen    = $urandom();
            mem_to_reg = $urandom();
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
